// File: rtl/rng_pool_if.sv
// rtl/rng_pool_if.sv - TRNG source and random word consumer handshakes for rng_pool
interface rng_pool_if #(
   parameter int TRNG_WIDTH   = 4,
   parameter int OUTPUT_WIDTH = 8
);
   logic [TRNG_WIDTH-1:0]   trng_word;
   logic                    trng_valid;
   logic                    trng_req;
   logic [OUTPUT_WIDTH-1:0] random_word;
   logic                    output_valid;
   logic                    output_ready;

   modport slave (
      input  trng_word,
      input  trng_valid,
      input  output_ready,
      output trng_req,
      output random_word,
      output output_valid
   );

   modport master (
      output trng_word,
      output trng_valid,
      output output_ready,
      input  trng_req,
      input  random_word,
      input  output_valid
   );
endinterface

// File: rtl/rng_pool.sv
// rtl/rng_pool.sv - packs raw TRNG words into wide random words, FIFO-buffers them
// and runs a repetition-count health test on the accepted entropy stream.
module rng_pool #(
   parameter int OUTPUT_WIDTH = 8,
   parameter int TRNG_WIDTH   = 4,
   parameter int DEPTH        = 4,
   parameter int REP_LIMIT    = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       en,
   rng_pool_if.slave                  bus,
   output logic [$clog2(DEPTH+1)-1:0] fill_level,
   output logic                       health_fail
);
   localparam int N      = OUTPUT_WIDTH / TRNG_WIDTH;
   localparam int BEAT_W = (N > 1) ? $clog2(N) : 1;
   localparam int PTR_W  = $clog2(DEPTH);
   localparam int FILL_W = $clog2(DEPTH + 1);
   localparam int REP_W  = $clog2(REP_LIMIT + 1);

   logic [OUTPUT_WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0]        wr_ptr;
   logic [PTR_W-1:0]        rd_ptr;
   logic [BEAT_W-1:0]       beat;
   logic [REP_W-1:0]        rep_cnt;
   logic [REP_W-1:0]        rep_next;
   logic [TRNG_WIDTH-1:0]   last_word;
   logic [OUTPUT_WIDTH-1:0] asm_shift;
   logic                    active;
   logic                    req;
   logic                    out_valid;
   logic                    accept;
   logic                    pop;
   logic                    last_beat;
   logic                    trip;
   logic                    push;

   // Reset also gates the handshakes so nothing is offered while state is being cleared.
   always_comb begin
      active    = !reset && en && !health_fail;
      req       = active && (fill_level < FILL_W'(DEPTH));
      out_valid = active && (fill_level != '0);
      accept    = req && bus.trng_valid;
      pop       = out_valid && bus.output_ready;
      rep_next  = (rep_cnt != '0 && bus.trng_word == last_word) ? rep_cnt + REP_W'(1)
                                                                 : REP_W'(1);
      trip      = accept && (rep_next == REP_W'(REP_LIMIT));
      last_beat = (beat == BEAT_W'(N - 1));
      push      = accept && last_beat && !trip;
   end

   assign bus.trng_req     = req;
   assign bus.output_valid = out_valid;
   assign bus.random_word  = out_valid ? mem[rd_ptr] : '0;

   // Only the N-1 older beats need storage; the final beat goes straight into the FIFO.
   generate
      if (N > 1) begin : g_asm
         logic [OUTPUT_WIDTH-TRNG_WIDTH-1:0] asm_q;

         always_ff @(posedge clk) begin
            if (reset || trip) begin
               asm_q <= '0;
            end else if (accept) begin
               asm_q <= asm_shift[OUTPUT_WIDTH-TRNG_WIDTH-1:0];
            end
         end

         assign asm_shift = {asm_q, bus.trng_word};
      end else begin : g_asm_single
         assign asm_shift = bus.trng_word;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         beat        <= '0;
         rep_cnt     <= '0;
         last_word   <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         fill_level  <= '0;
         health_fail <= 1'b0;
      end else begin
         if (accept) begin
            last_word <= bus.trng_word;
            rep_cnt   <= rep_next;
         end
         // A tripping word flushes everything and is never pushed, even on the last beat.
         if (trip) begin
            health_fail <= 1'b1;
            beat        <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fill_level  <= '0;
         end else begin
            if (accept) begin
               beat <= last_beat ? '0 : beat + BEAT_W'(1);
            end
            if (push) begin
               wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
               rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
               fill_level <= fill_level + FILL_W'(1);
            end else if (pop && !push) begin
               fill_level <= fill_level - FILL_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= asm_shift;
      end
   end
endmodule

// File: tb/tb_rng_pool.sv
// tb/tb_rng_pool.sv - randomized and directed checks of rng_pool against a queue model
module tb_rng_pool;
   localparam int OW        = 8;
   localparam int TW        = 4;
   localparam int DEPTH     = 4;
   localparam int REP_LIMIT = 8;
   localparam int N         = OW / TW;
   localparam int FW        = $clog2(DEPTH + 1);

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          en = 1'b0;
   logic [FW-1:0] fill_level;
   logic          health_fail;

   rng_pool_if #(.TRNG_WIDTH(TW), .OUTPUT_WIDTH(OW)) bus ();

   rng_pool #(
      .OUTPUT_WIDTH(OW),
      .TRNG_WIDTH  (TW),
      .DEPTH       (DEPTH),
      .REP_LIMIT   (REP_LIMIT)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .en         (en),
      .bus        (bus),
      .fill_level (fill_level),
      .health_fail(health_fail)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference model: completed words in a queue, partial word as an integer.
   logic [OW-1:0] q[$];
   logic [OW-1:0] part;
   int            beats;
   int            rep;
   logic [TW-1:0] last;
   bit            fail;

   task automatic model_clear();
      q.delete();
      part  = '0;
      beats = 0;
      rep   = 0;
      last  = '0;
      fail  = 1'b0;
   endtask

   task automatic step(input bit e, input bit r, input bit v, input logic [TW-1:0] w,
                       input bit rdy);
      bit            ereq;
      bit            eov;
      logic [OW-1:0] erw;
      en               = e;
      reset            = r;
      bus.trng_valid   = v;
      bus.trng_word    = w;
      bus.output_ready = rdy;
      #1;
      ereq = !r && e && !fail && (q.size() < DEPTH);
      eov  = !r && e && !fail && (q.size() != 0);
      erw  = eov ? q[0] : '0;
      check("trng_req", bus.trng_req, ereq);
      check("output_valid", bus.output_valid, eov);
      check("random_word", bus.random_word, erw);
      check("fill_level", fill_level, q.size());
      check("health_fail", health_fail, fail);
      @(posedge clk);
      if (r) begin
         model_clear();
      end else begin
         if (eov && rdy) void'(q.pop_front());
         if (ereq && v) begin
            rep  = (rep != 0 && w == last) ? rep + 1 : 1;
            last = w;
            if (rep == REP_LIMIT) begin
               fail  = 1'b1;
               q.delete();
               part  = '0;
               beats = 0;
            end else begin
               part = (part << TW) | OW'(w);
               beats++;
               if (beats == N) begin
                  q.push_back(part);
                  part  = '0;
                  beats = 0;
               end
            end
         end
      end
      @(negedge clk);
   endtask

   initial begin
      logic [OW-1:0] exp_order [3];
      bus.trng_word    = '0;
      bus.trng_valid   = 1'b0;
      bus.output_ready = 1'b0;
      model_clear();
      @(negedge clk);

      step(1'b0, 1'b1, 1'b0, 4'h0, 1'b0);
      step(1'b1, 1'b1, 1'b1, 4'h3, 1'b1);
      check("reset_fill", fill_level, 0);
      check("reset_fail", health_fail, 0);

      // Two beats assemble MSB-first and appear the next cycle
      step(1'b1, 1'b0, 1'b1, 4'hA, 1'b0);
      step(1'b1, 1'b0, 1'b1, 4'h5, 1'b0);
      check("a5_word", bus.random_word, 8'hA5);
      check("a5_valid", bus.output_valid, 1);
      check("a5_fill", fill_level, 1);
      step(1'b1, 1'b0, 1'b0, 4'h0, 1'b1);
      check("pop_fill", fill_level, 0);
      check("pop_valid", bus.output_valid, 0);

      // Fill to full, pop at full, then simultaneous push/pop at fill_level 3
      for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, 1'b1, 4'(i), 1'b0);
      check("full_fill", fill_level, DEPTH);
      check("full_req", bus.trng_req, 0);
      step(1'b1, 1'b0, 1'b1, 4'h9, 1'b1);
      check("refill_req", bus.trng_req, 1);
      check("head_34", bus.random_word, 8'h34);
      step(1'b1, 1'b0, 1'b1, 4'h9, 1'b0);
      step(1'b1, 1'b0, 1'b1, 4'hA, 1'b1);
      check("pushpop_fill", fill_level, 3);
      exp_order[0] = 8'h56;
      exp_order[1] = 8'h78;
      exp_order[2] = 8'h9A;
      for (int i = 0; i < 3; i++) begin
         check("wrap_order", bus.random_word, exp_order[i]);
         step(1'b1, 1'b0, 1'b0, 4'h0, 1'b1);
      end
      check("drained", fill_level, 0);

      // Repetition-count health test
      step(1'b0, 1'b1, 1'b0, 4'h0, 1'b0);
      for (int i = 0; i < REP_LIMIT - 1; i++) step(1'b1, 1'b0, 1'b1, 4'h3, 1'b0);
      check("rep7_fail", health_fail, 0);
      check("rep7_fill", fill_level, 3);
      step(1'b1, 1'b0, 1'b1, 4'h3, 1'b0);
      check("rep8_fail", health_fail, 1);
      check("rep8_fill", fill_level, 0);
      check("rep8_req", bus.trng_req, 0);
      step(1'b1, 1'b0, 1'b1, 4'h3, 1'b1);
      check("sticky_fail", health_fail, 1);

      // Enable drop holds the partial word
      step(1'b0, 1'b1, 1'b0, 4'h0, 1'b0);
      step(1'b1, 1'b0, 1'b1, 4'hC, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 4'($urandom_range(0, 15)), 1'b1);
      step(1'b1, 1'b0, 1'b1, 4'h1, 1'b0);
      check("en_resume", bus.random_word, 8'hC1);

      // Reset mid-assembly discards the partial word
      step(1'b1, 1'b0, 1'b1, 4'h7, 1'b0);
      step(1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
      step(1'b1, 1'b0, 1'b1, 4'h2, 1'b0);
      step(1'b1, 1'b0, 1'b1, 4'h9, 1'b0);
      check("reset_discard", bus.random_word, 8'h29);
      check("reset_discard_fill", fill_level, 1);

      // Random traffic; the second half uses a 2-symbol alphabet to trip the health test
      for (int i = 0; i < 1500; i++) begin
         bit            rs;
         logic [TW-1:0] w;
         rs = fail && ($urandom_range(0, 7) == 0);
         w  = (i < 750) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 1));
         step(($urandom_range(0, 7) != 0), rs, ($urandom_range(0, 3) != 0), w,
              ($urandom_range(0, 1) == 1));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
